// File: rtl/button_conditioner.sv
// Push-button front end: polarity fix, 2-flop synchronizer, per-channel
// debounce counter, registered press/release pulses and optional per-channel
// toggle latching. All outputs come straight from flops.
module button_conditioner #(
  parameter int          DEBOUNCE_CYCLES    = 50000,
  parameter bit          ACTIVE_LOW_BUTTONS = 1'b1,
  parameter logic [2:0]  TOGGLE_MASK        = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] raw_button,
  output logic       bit_0,
  output logic       bit_1,
  output logic       bit_2,
  output logic [2:0] press_pulse,
  output logic [2:0] release_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    POLARITY = {3{ACTIVE_LOW_BUTTONS}};

  logic [2:0]    pressed_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    stable;
  logic [2:0]    toggle_q;
  logic [2:0]    accept;
  logic [CW-1:0] cnt [3];

  // Inverting before the synchronizer keeps every flop reset value meaning "released".
  assign pressed_raw = raw_button ^ POLARITY;

  // Two-flop synchronizer per channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= pressed_raw;
      sync2 <= sync1;
    end
  end

  // A channel accepts its new level on the edge that completes the stable window.
  always_comb begin
    accept = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if ((sync2[i] != stable[i]) && (cnt[i] == CNT_LAST)) begin
        accept[i] = 1'b1;
      end else begin
        accept[i] = 1'b0;
      end
    end
  end

  // Debounce counters: any return to the stable level restarts the window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Edge pulses line up with the cycle in which the new stable level is visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_pulse   <= 3'b000;
      release_pulse <= 3'b000;
    end else begin
      press_pulse   <= accept & sync2;
      release_pulse <= accept & ~sync2;
    end
  end

  // Toggle latches flip on accepted presses, only on masked channels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 3'b000;
    end else begin
      toggle_q <= toggle_q ^ (accept & sync2 & TOGGLE_MASK);
    end
  end

  // Static per-channel select between level and toggle flops.
  assign bit_0 = TOGGLE_MASK[0] ? toggle_q[0] : stable[0];
  assign bit_1 = TOGGLE_MASK[1] ? toggle_q[1] : stable[1];
  assign bit_2 = TOGGLE_MASK[2] ? toggle_q[2] : stable[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (level-only and ch2-toggle)
// share stimulus; a sample-window model predicts outputs every cycle.
module tb_button_conditioner;

  localparam int         D     = 4;
  localparam logic [2:0] TMASK = 3'b100;

  logic       clock;
  logic       reset_n;
  logic [2:0] raw_button;

  logic       a_b0, a_b1, a_b2;
  logic [2:0] a_press, a_release;
  logic       t_b0, t_b1, t_b2;
  logic [2:0] t_press, t_release;

  int errors;
  int checks;
  bit check_en;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW_BUTTONS(1'b1), .TOGGLE_MASK(3'b000)) dut (
    .clock(clock), .reset_n(reset_n), .raw_button(raw_button),
    .bit_0(a_b0), .bit_1(a_b1), .bit_2(a_b2),
    .press_pulse(a_press), .release_pulse(a_release)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW_BUTTONS(1'b1), .TOGGLE_MASK(TMASK)) dut_t (
    .clock(clock), .reset_n(reset_n), .raw_button(raw_button),
    .bit_0(t_b0), .bit_1(t_b1), .bit_2(t_b2),
    .press_pulse(t_press), .release_pulse(t_release)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: hist[0] is the pressed level sampled at the previous edge. A level is
  // accepted when the D samples that reached the compare stage all disagree
  // with the accepted level.
  logic [2:0] hist [0:D];
  logic [2:0] m_stable, m_press, m_release, m_tog, flip;

  always_comb begin
    flip = 3'b111;
    for (int j = 1; j <= D; j++) flip = flip & (hist[j] ^ m_stable);
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= D; j++) hist[j] <= 3'b000;
      m_stable  <= 3'b000;
      m_press   <= 3'b000;
      m_release <= 3'b000;
      m_tog     <= 3'b000;
    end else begin
      m_stable  <= m_stable ^ flip;
      m_press   <= flip & ~m_stable;
      m_release <= flip & m_stable;
      m_tog     <= m_tog ^ (flip & ~m_stable);
      hist[0]   <= ~raw_button;
      for (int j = 1; j <= D; j++) hist[j] <= hist[j-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (check_en) begin
        check("lvl_bits", {29'd0, a_b2, a_b1, a_b0}, {29'd0, m_stable});
        check("lvl_press", {29'd0, a_press}, {29'd0, m_press});
        check("lvl_release", {29'd0, a_release}, {29'd0, m_release});
        check("tgl_bits", {29'd0, t_b2, t_b1, t_b0}, {29'd0, (m_tog & TMASK) | (m_stable & ~TMASK)});
        check("tgl_press", {29'd0, t_press}, {29'd0, m_press});
        check("tgl_release", {29'd0, t_release}, {29'd0, m_release});
        check("pulse_excl", {29'd0, a_press & a_release}, 32'd0);
      end
    end
  end

  initial begin
    errors     = 0;
    checks     = 0;
    check_en   = 1'b0;
    raw_button = 3'b111;
    reset_n    = 1'b0;

    // 1. reset state
    #2;
    check("rst_now_bits", {29'd0, a_b2, a_b1, a_b0}, 32'd0);
    negs(3);
    check("rst_held_bits", {29'd0, a_b2, a_b1, a_b0}, 32'd0);
    check("rst_held_pulses", {26'd0, a_press, a_release}, 32'd0);
    reset_n  = 1'b1;
    check_en = 1'b1;
    negs(3);
    check("idle_bits", {29'd0, a_b2, a_b1, a_b0}, 32'd0);

    // 2. clean press / release on ch0
    raw_button = 3'b110;
    negs(5);
    check("ch0_press_e4", {31'd0, a_b0}, 32'd0);
    negs(1);
    check("ch0_press_e5", {31'd0, a_b0}, 32'd1);
    check("ch0_press_pulse", {29'd0, a_press}, 32'h1);
    check("model_pin_press", {29'd0, m_stable}, 32'h1);
    negs(1);
    check("ch0_press_pulse_end", {29'd0, a_press}, 32'h0);
    raw_button = 3'b111;
    negs(5);
    check("ch0_rel_e4", {31'd0, a_b0}, 32'd1);
    negs(1);
    check("ch0_rel_e5", {31'd0, a_b0}, 32'd0);
    check("ch0_rel_pulse", {29'd0, a_release}, 32'h1);
    negs(1);
    check("ch0_rel_pulse_end", {29'd0, a_release}, 32'h0);

    // 3. bounce on ch1
    raw_button = 3'b101;
    negs(3);
    raw_button = 3'b111;
    negs(1);
    raw_button = 3'b101;
    negs(5);
    check("ch1_bounce_e4", {31'd0, a_b1}, 32'd0);
    check("ch1_bounce_nopulse", {29'd0, a_press}, 32'h0);
    negs(1);
    check("ch1_bounce_e5", {31'd0, a_b1}, 32'd1);
    check("ch1_bounce_pulse", {29'd0, a_press}, 32'h2);
    raw_button = 3'b111;
    negs(8);

    // 4a. glitch on ch2
    raw_button = 3'b011;
    negs(3);
    raw_button = 3'b111;
    negs(8);
    check("ch2_glitch_bit", {31'd0, a_b2}, 32'd0);
    check("model_pin_glitch", {29'd0, m_stable}, 32'h0);

    // 5. toggle on ch2 (dut_t), two press/release cycles
    raw_button = 3'b011;
    negs(6);
    check("tgl_press1", {29'd0, t_b2, t_b1, t_b0}, 32'h4);
    raw_button = 3'b111;
    negs(6);
    check("tgl_rel1_bit", {31'd0, t_b2}, 32'd1);
    check("tgl_rel1_pulse", {29'd0, t_release}, 32'h4);
    raw_button = 3'b011;
    negs(6);
    check("tgl_press2", {31'd0, t_b2}, 32'd0);
    check("tgl_press2_pulse", {29'd0, t_press}, 32'h4);
    raw_button = 3'b111;
    negs(6);
    check("tgl_rel2_bit", {31'd0, t_b2}, 32'd0);

    // 4b. all three pressed together
    raw_button = 3'b000;
    negs(5);
    check("all_e4", {29'd0, a_b2, a_b1, a_b0}, 32'h0);
    negs(1);
    check("all_e5", {29'd0, a_b2, a_b1, a_b0}, 32'h7);
    check("all_pulse", {29'd0, a_press}, 32'h7);
    check("all_tgl", {29'd0, t_b2, t_b1, t_b0}, 32'h7);
    raw_button = 3'b111;
    negs(6);
    check("all_rel_pulse", {29'd0, a_release}, 32'h7);
    check("all_rel_tgl", {29'd0, t_b2, t_b1, t_b0}, 32'h4);

    // 6. reset mid-count on ch0 while ch1 is already accepted
    raw_button = 3'b101;
    negs(6);
    check("pre_rst_b1", {31'd0, a_b1}, 32'd1);
    raw_button = 3'b100;
    negs(4);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_lvl", {29'd0, a_b2, a_b1, a_b0}, 32'h0);
    check("async_rst_tgl", {29'd0, t_b2, t_b1, t_b0}, 32'h0);
    negs(3);
    check("rst_hold_b0", {31'd0, a_b0}, 32'd0);
    reset_n = 1'b1;
    negs(5);
    check("post_rst_e4", {29'd0, a_b2, a_b1, a_b0}, 32'h0);
    negs(1);
    check("post_rst_e5", {29'd0, a_b2, a_b1, a_b0}, 32'h3);
    check("post_rst_pulse", {29'd0, a_press}, 32'h3);
    raw_button = 3'b111;
    negs(8);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input front end for the push-button lab designs. It synchronizes, inverts and debounces three raw push-button inputs, then drives the clean level signals bit_0, bit_1 and bit_2 that feed the registered gate/adder/MUX core. It also provides one-cycle press and release pulses, plus an optional per-button toggle (latching) mode so a momentary key can act as a switch.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a level change is accepted (1 ms at 50 MHz); legal range ≥1; use 4 in simulation.
ACTIVE_LOW_BUTTONS, 1, 1 = raw_button low means pressed (board KEYs); 0 = active-high.
TOGGLE_MASK, 3'b000, bit i set = bit_i toggles on each press instead of following the debounced level.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset_n  input  1  asynchronous, active-low reset.
raw_button  input  3  unsynchronized button pins; index i maps to bit_i.
bit_0  output  1  conditioned button 0 (1 = pressed, or toggle state).
bit_1  output  1  conditioned button 1.
bit_2  output  1  conditioned button 2.
press_pulse  output  3  one-cycle high when a debounced press is accepted on channel i.
release_pulse  output  3  one-cycle high when a debounced release is accepted on channel i.

Behaviour:
- One clock. Reset is asynchronous and active-low (reset_n). Every flop clears immediately when reset_n is low.
- Polarity: pressed_raw[i] = raw_button[i] XOR ACTIVE_LOW_BUTTONS. Inversion happens before the synchronizer.
- Synchronizer: 2-flop chain per channel (sync1, sync2). Reset value 0 (released).
- Debounce, per channel and fully independent:
  - Registers: stable[i] (reset 0) and counter cnt[i], width $clog2(DEBOUNCE_CYCLES+1) (reset 0).
  - Each edge, if sync2 == stable: cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any bounce back to the stable level before acceptance clears cnt, so the full window restarts.
- Latency: raw level set before edge E and held is accepted at edge E+DEBOUNCE_CYCLES+1 (2 sync edges + DEBOUNCE_CYCLES compare edges, counting E as the first). Accepted change is visible on outputs after that edge.
- Pulses:
  - press_pulse[i] is registered and high for exactly the cycle after stable[i] goes 0→1. release_pulse[i] is the same for 1→0.
  - Never both high on one channel in the same cycle.
  - Reset value 0.
- Toggle:
  - toggle_q[i] (reset 0) inverts on the same edge stable[i] rises, only where TOGGLE_MASK[i]=1.
  - Releases do not affect it.
- Outputs: bit_i = TOGGLE_MASK[i] ? toggle_q[i] : stable[i]. Driven directly from flops, no combinational path from raw_button.
- Simultaneous events: channels never interact. Presses on all three in the same cycle produce three accepted edges on the same cycle.
- Reset mid-count: cnt, stable, sync and toggle state all clear. After reset_n releases with a button still held, the full latency applies again from the first edge.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.
- DEBOUNCE_CYCLES=1: accepts after one mismatching compare edge.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW_BUTTONS=1 unless stated):
1. Reset: raw_button=3'b111, reset_n low for 3 cycles, including asynchronously mid-cycle -> bit_0..2=0, press_pulse=0, release_pulse=0 immediately, and held.
2. Clean press/release on ch0: raw[0] 1→0 before edge E, held -> bit_0=1 after edge E+5, press_pulse=3'b001 for exactly one cycle. Then raw[0] 0→1 -> bit_0=0 five edges later, release_pulse=3'b001 for one cycle.
3. Bounce on ch1: raw[1] low 3 cycles, high 1, low held -> bit_1 rises 5 edges after the final falling edge, exactly one press_pulse[1].
4. Glitch on ch2: raw[2] low for 3 cycles, then high -> bit_2 stays 0, no pulses. Also press all three channels on the same cycle -> all bits rise on the same edge, press_pulse=3'b111.
5. Toggle with TOGGLE_MASK=3'b100: two full press/release cycles on ch2 -> bit_2 goes 0→1 at first press, 1→0 at second press, unchanged at releases, release_pulse still produced. bit_0 and bit_1 remain level-following.
6. Reset mid-operation: ch0 held, reset_n pulsed low when cnt=2 -> bit_0=0. After reset_n high with raw[0] still low, bit_0 rises 5 edges later.
